// File: rtl/ctrl_pkg.sv
// Shared frame-buffer definitions: FSM states, frame size and result-memory address fields.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FRAME_WORDS = 192;
    localparam int ADDR_W      = 8;

    localparam int CHA_HI = 7;
    localparam int CHA_LO = 6;
    localparam int ROW_HI = 5;
    localparam int ROW_LO = 3;
    localparam int COL_HI = 2;
    localparam int COL_LO = 0;

endpackage

// File: rtl/write_ctrl_s2.sv
// Result-memory write controller: accepts one frame of samples and writes them at consecutive addresses.
// Writes appear 1 cycle after acceptance; in_ready stalls upstream outside WRITE. Optional err via WRITE_CTRL_ERR_EN.
module write_ctrl_s2
    import ctrl_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int N_WORDS = FRAME_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_rdy,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 we_b,
    output logic [ADDR_W-1:0]    dir_B,
    output logic [DATA_W-1:0]    din_b,
    output logic [1:0]           cha_addr,
    output logic [2:0]           row_addr,
    output logic [2:0]           col_addr,
    output logic                 data_done,
    output logic                 busy
`ifdef WRITE_CTRL_ERR_EN
    ,
    output logic                 err
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic                armed;
    logic                accept;
    logic                last;

    assign accept = in_valid & in_ready;
    assign last   = accept && (cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (data_rdy && armed) state_nxt = ST_WRITE;
            ST_WRITE: if (last) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        data_done = 1'b0;
        case (state)
            ST_WRITE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_FLUSH: busy = 1'b1;
            ST_DONE: begin
                busy      = 1'b1;
                data_done = 1'b1;
            end
            default: ;
        endcase
    end

    // The counter holds at the last index on the final acceptance so it never passes N_WORDS-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            dir_B <= '0;
            din_b <= '0;
            we_b  <= 1'b0;
            armed <= 1'b1;
        end else begin
            we_b <= accept;
            if (accept) begin
                dir_B <= cnt;
                din_b <= in_data;
            end
            if (state == ST_IDLE && state_nxt == ST_WRITE) begin
                cnt <= '0;
            end else if (accept && !last) begin
                cnt <= cnt + 1'b1;
            end
            // A low data_rdy re-arms even while entering DONE: the level has already dropped.
            if (!data_rdy) begin
                armed <= 1'b1;
            end else if (state != ST_DONE && state_nxt == ST_DONE) begin
                armed <= 1'b0;
            end
        end
    end

    assign cha_addr = dir_B[CHA_HI:CHA_LO];
    assign row_addr = dir_B[ROW_HI:ROW_LO];
    assign col_addr = dir_B[COL_HI:COL_LO];

`ifdef WRITE_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((state == ST_WRITE && !data_rdy) ||
                     ((state == ST_FLUSH || state == ST_DONE) && in_valid)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
